pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register, the successor to the plain sync-load register used for the PC and simple datapath registers.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a configurable reset value.
- Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and toward the UART side.
- Sustains 1 transfer/clock under back-pressure with a fully registered in_ready.

---
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and configurable reset value. Define PIPE_STATS_EN to add stall/bubble counters.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH        = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = {DATA_WIDTH{1'b0}},
  parameter bit                    FLUSH_CLEARS_DATA = 1'b0,
  parameter int                    CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q,  main_d;
  logic [DATA_WIDTH-1:0] skid_q,  skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  accept;
  logic                  pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready_q is low here, so only a pop can move us.
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush kills everything in flight, including this cycle's input beat.
    if (flush) begin
      state_d = ST_EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_d = RESET_VALUE;
        skid_d = RESET_VALUE;
      end
    end

    // Registered ready: look ahead at the next state instead of the current inputs.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q,  stall_d;
  logic [CNT_WIDTH-1:0] bubble_q, bubble_d;

  // Saturating counters; only rst clears them, flush leaves them alone.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if (!out_valid && (bubble_q != {CNT_WIDTH{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  // CNT_WIDTH only sizes the statistics counters, which are absent in this build.
  if (CNT_WIDTH < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus random traffic,
// checked against a queue model of the stage contents.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, fc_in_ready, fc_out_valid;
  logic [31:0] out_data, fc_out_data;
  logic [1:0]  occupancy, fc_occupancy;
`ifdef PIPE_STATS_EN
  logic [3:0]  stall_cnt, bubble_cnt, fc_stall_cnt, fc_bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected stage contents, oldest first: this is the scoreboard.
  logic [31:0] exp_q[$];
  int          exp_stall  = 0;
  int          exp_bubble = 0;

  pipe_stage_reg #(.DATA_WIDTH(32), .RESET_VALUE(RV), .FLUSH_CLEARS_DATA(1'b0), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_reg #(.DATA_WIDTH(32), .RESET_VALUE(RV), .FLUSH_CLEARS_DATA(1'b1), .CNT_WIDTH(4)) dut_fc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(fc_in_ready), .in_data(in_data),
    .out_valid(fc_out_valid), .out_ready(out_ready), .out_data(fc_out_data),
    .occupancy(fc_occupancy)
`ifdef PIPE_STATS_EN
    , .stall_cnt(fc_stall_cnt), .bubble_cnt(fc_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Monitor: compare outputs to the model at the falling edge, then advance
  // the model by the transfer that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      check("in_ready",  {31'b0, in_ready},  {31'b0, exp_q.size() < 2});
      check("occupancy", {30'b0, occupancy}, 32'(exp_q.size()));
      check("fc_occupancy", {30'b0, fc_occupancy}, 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0]);
        check("fc_out_data", fc_out_data, exp_q[0]);
      end
`ifdef PIPE_STATS_EN
      check("stall_cnt",  {28'b0, stall_cnt},  32'(exp_stall));
      check("bubble_cnt", {28'b0, bubble_cnt}, 32'(exp_bubble));
      if (exp_q.size() != 0 && !out_ready && exp_stall < 15) exp_stall++;
      if (exp_q.size() == 0 && exp_bubble < 15) exp_bubble++;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        automatic bit acc = in_valid && (exp_q.size() < 2);
        automatic bit pp  = out_ready && (exp_q.size() != 0);
        if (pp)  void'(exp_q.pop_front());
        if (acc) exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  out_data, RV);
    check("rst_occupancy", {30'b0, occupancy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Three empty cycles after reset.
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
`ifdef PIPE_STATS_EN
    check("bubble_after_rst", {28'b0, bubble_cnt}, 32'd3);
`endif

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) drive(1, 32'(i), 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // Back-pressure; 0xC is offered while in_ready is low and must be ignored.
    drive(1, 32'hA, 0, 0);
    drive(1, 32'hB, 0, 0);
    drive(1, 32'hC, 0, 0);
    drive(0, 0, 0, 0);
    check("bp_occupancy", {30'b0, occupancy}, 32'd2);
    check("bp_in_ready",  {31'b0, in_ready},  32'd0);
    check("bp_out_data",  out_data, 32'hA);
    for (int i = 0; i < 18; i++) drive(0, 0, 0, 0);
`ifdef PIPE_STATS_EN
    check("stall_saturated", {28'b0, stall_cnt}, 32'd15);
`endif
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("bp_drained", {30'b0, occupancy}, 32'd0);

    // Flush from FULL together with an input beat.
    drive(1, 32'h11, 0, 0);
    drive(1, 32'h22, 0, 0);
    drive(1, 32'h33, 0, 1);
    drive(0, 0, 1, 0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready",  {31'b0, in_ready},  32'd1);
    check("flush_occupancy", {30'b0, occupancy}, 32'd0);
    check("flush_keeps_data", out_data, 32'h11);
    check("flush_clears_data", fc_out_data, RV);
`ifdef PIPE_STATS_EN
    check("flush_keeps_stall", {28'b0, stall_cnt}, 32'd15);
`endif
    drive(0, 0, 1, 0);

    // Simultaneous push and pop in ONE.
    drive(1, 32'h5, 0, 0);
    drive(1, 32'h6, 1, 0);
    drive(0, 0, 0, 0);
    check("pushpop_data", out_data, 32'h6);
    check("pushpop_occupancy", {30'b0, occupancy}, 32'd1);
    drive(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom, $urandom_range(2, 0) != 0,
            $urandom_range(31, 0) == 0);
    end

    // Asynchronous reset in the middle of a cycle with data held.
    drive(1, 32'h77, 0, 0);
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    check("midrst_out_data",  out_data, RV);
    check("midrst_occupancy", {30'b0, occupancy}, 32'd0);
`ifdef PIPE_STATS_EN
    check("midrst_stall", {28'b0, stall_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 32'h99, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
